// File: rtl/aes256_key_sched_ctrl.sv
// aes256_key_sched_ctrl: sequences the AES-256 key expansion engine and delivers round keys 0..NR.
// Optional round-key cache and reverse replay when AES_RK_CACHE_EN is defined.
module aes256_key_sched_ctrl #(
    parameter int         NR        = 14,
    parameter logic [3:0] HOLD_CODE = 4'd2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key_in,
    input  logic         dec,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         err,
    output logic [255:0] exp_key,
    output logic [3:0]   exp_state,
    output logic [3:0]   exp_round,
    output logic [4:0]   exp_cnt,
    output logic         exp_inv_en,
    input  logic [127:0] exp_round_key
);
    typedef enum logic [2:0] {IDLE, LOAD, CAPT, OUT, EXPAND, REPLAY} state_t;
    localparam logic [3:0] LAST = 4'(NR);
    state_t       state;
    logic [255:0] key_reg;
    logic [3:0]   r;
    logic [2:0]   cnt;
    logic [3:0]   r_nxt;
    assign r_nxt      = r + 4'd1;
    assign exp_key    = key_reg;
    assign exp_inv_en = 1'b0;
`ifdef AES_RK_CACHE_EN
    logic [127:0] cache [0:NR];
    logic         cache_ok;
    logic         rev;
    logic         hit;
    logic [3:0]   first;
    logic [3:0]   step;
    assign hit     = cache_ok && key_in == key_reg;
    assign first   = dec ? LAST : 4'd0;
    assign step    = rev ? rk_round - 4'd1 : rk_round + 4'd1;
    assign rk_last = rk_valid && rk_round == (rev ? 4'd0 : LAST);
    always_ff @(posedge clk)
        if (state == CAPT) cache[r] <= exp_round_key;
`else
    assign rk_last = rk_valid && rk_round == LAST;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_reg   <= '0;
            r         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_data   <= '0;
            rk_round  <= '0;
            err       <= 1'b0;
            exp_state <= '0;
            exp_round <= '0;
            exp_cnt   <= '0;
`ifdef AES_RK_CACHE_EN
            cache_ok  <= 1'b0;
            rev       <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    exp_state <= 4'd0;
                    exp_round <= 4'd0;
                    exp_cnt   <= 5'd6;
                    if (start) begin
`ifdef AES_RK_CACHE_EN
                        if (hit) begin
                            state     <= REPLAY;
                            busy      <= 1'b1;
                            rev       <= dec;
                            exp_state <= HOLD_CODE;
                            rk_valid  <= 1'b1;
                            rk_round  <= first;
                            rk_data   <= cache[first];
                        end else
`endif
                        if (dec) err <= 1'b1;
                        else begin
                            state   <= LOAD;
                            busy    <= 1'b1;
                            key_reg <= key_in;
                            r       <= 4'd0;
`ifdef AES_RK_CACHE_EN
                            cache_ok <= 1'b0;
`endif
                        end
                    end
                end
                LOAD: begin
                    state     <= CAPT;
                    exp_state <= 4'd1;
                    exp_round <= 4'd0;
                end
                CAPT: begin
                    state     <= OUT;
                    rk_valid  <= 1'b1;
                    rk_data   <= exp_round_key;
                    rk_round  <= r;
                    exp_state <= HOLD_CODE;
`ifdef AES_RK_CACHE_EN
                    if (r == LAST) cache_ok <= 1'b1;
`endif
                end
                OUT: if (rk_ready) begin
                    rk_valid <= 1'b0;
                    if (r == LAST) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        exp_state <= 4'd0;
                        exp_round <= 4'd0;
                    end else begin
                        r         <= r_nxt;
                        cnt       <= 3'd0;
                        exp_state <= 4'd1;
                        exp_round <= r_nxt;
                        state     <= r_nxt < 4'd2 ? CAPT : EXPAND;
                        exp_cnt   <= r_nxt < 4'd2 ? 5'd6 : 5'd0;
                    end
                end
                EXPAND: if (cnt == 3'd5) begin
                    state     <= CAPT;
                    exp_state <= HOLD_CODE;
                    exp_cnt   <= 5'd6;
                end else begin
                    cnt     <= cnt + 3'd1;
                    exp_cnt <= {2'b00, 3'(cnt + 3'd1)};
                end
`ifdef AES_RK_CACHE_EN
                REPLAY: if (rk_ready) begin
                    if (rk_round == (rev ? 4'd0 : LAST)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        rk_valid  <= 1'b0;
                        exp_state <= 4'd0;
                    end else begin
                        rk_round <= step;
                        rk_data  <= cache[step];
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
